// File: rtl/router_pkg.sv
// Shared ring-router definitions: packet width, header field positions, packet type.
// ROUTER_OUT_HOPSHIFT_EN selects the hop-field shift helper in router_output_ctrl.
package router_pkg;

  localparam int unsigned PKT_W   = 64;
  localparam int unsigned VC_BIT  = 63;
  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;

  typedef logic [PKT_W-1:0] pkt_t;

  // Logical right shift of the hop field only; every other bit passes through.
  function automatic pkt_t hop_shift(pkt_t p);
    pkt_t r;
    r = p;
    r[HOP_MSB:HOP_LSB] = {1'b0, p[HOP_MSB:HOP_LSB+1]};
    return r;
  endfunction

endpackage

// File: rtl/router_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module router_rr_arb #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_ctrl.sv
// Ring-router output port: arbitrates requesters into even/odd VC buffers, drains over so/ro.
// Optional ROUTER_OUT_HOPSHIFT_EN halves the hop field as each packet is written.
module router_output_ctrl
  import router_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PKT_W   = router_pkg::PKT_W,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     polarity,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*PKT_W-1:0] din,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     so,
  input  logic                     ro,
  output logic [PKT_W-1:0]         dout
);

  logic [PKT_W-1:0] even_buf, odd_buf;
  logic             even_full, odd_full;
  logic [PTR_W-1:0] ptr_even, ptr_odd;

  logic             wr_full;
  logic             send_full;
  logic [PTR_W-1:0] arb_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_next;
  logic             grant_any;
  logic [PKT_W-1:0] sel_din;
  logic [PKT_W-1:0] wr_pkt;

  // polarity=0: internal side fills even, link drains odd; polarity=1 swaps roles.
  assign wr_full   = polarity ? odd_full : even_full;
  assign send_full = polarity ? even_full : odd_full;
  assign arb_ptr   = polarity ? ptr_odd : ptr_even;

  router_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (arb_ptr),
    .en      (!wr_full),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant_any = |gnt;
  assign ptr_next  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  always_comb begin
    sel_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_din = din[i*PKT_W +: PKT_W];
    end
  end

`ifdef ROUTER_OUT_HOPSHIFT_EN
  assign wr_pkt = PKT_W'(hop_shift(pkt_t'(sel_din)));
`else
  assign wr_pkt = sel_din;
`endif

  assign so   = send_full & ro;
  assign dout = polarity ? even_buf : odd_buf;

  // Write and send always hit opposite buffers, so both updates may share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      even_buf  <= '0;
      odd_buf   <= '0;
      even_full <= 1'b0;
      odd_full  <= 1'b0;
      ptr_even  <= '0;
      ptr_odd   <= '0;
    end else begin
      if (grant_any) begin
        if (polarity) begin
          odd_buf  <= wr_pkt;
          odd_full <= 1'b1;
          ptr_odd  <= ptr_next;
        end else begin
          even_buf  <= wr_pkt;
          even_full <= 1'b1;
          ptr_even  <= ptr_next;
        end
      end
      if (so) begin
        if (polarity) even_full <= 1'b0;
        else          odd_full  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_output_ctrl.sv
// Directed self-checking bench for router_output_ctrl (NUM_REQ=3, PKT_W=64).
module tb_router_output_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         polarity;
  logic [2:0]   req;
  logic [191:0] din;
  logic [2:0]   gnt;
  logic         so;
  logic         ro;
  logic [63:0]  dout;

  int errors = 0;
  int checks = 0;

  router_output_ctrl #(
    .NUM_REQ (3),
    .PKT_W   (64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .so       (so),
    .ro       (ro),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] P0 = 64'h0000_0000_0000_0011;
  localparam logic [63:0] P1 = 64'h0000_0000_0000_0022;
  localparam logic [63:0] P2 = 64'h0000_0000_0000_0033;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; ro = 1'b1; polarity = 1'b0; din = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; ro = 1'b1; polarity = 1'b0; din = '0;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b want=000", gnt); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL reset_so got=%b want=0", so); end
    checks++; if (dout !== 64'h0) begin errors++; $display("FAIL reset_dout got=%h want=0", dout); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_idle();
    ro = 1'b1; req = '0;
    for (int c = 0; c < 6; c++) begin
      polarity = c[0];
      @(negedge clk);
      checks++;
      if (so !== 1'b0 || gnt !== 3'b000 || dout !== 64'h0) begin
        errors++; $display("FAIL idle c=%0d got so=%b gnt=%b dout=%h want 0", c, so, gnt, dout);
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    polarity = 1'b0; req = 3'b001; din = '0; din[63:0] = 64'hA5;
    @(negedge clk);
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got=%b want=001", gnt); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL single_so0 got=%b want=0", so); end
    tick();
    polarity = 1'b1; req = 3'b000;
    @(negedge clk);
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL single_so1 got=%b want=1", so); end
    checks++; if (dout !== 64'hA5) begin errors++; $display("FAIL single_dout got=%h want=a5", dout); end
    tick();
    polarity = 1'b0;
    @(negedge clk);
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL single_so2 got=%b want=0", so); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_gnt [7];
    logic [63:0] exp_dout [7];
    exp_gnt  = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    exp_dout = '{64'h0, P0, P0, P1, P1, P2, P2};
    do_reset();
    ro = 1'b1; req = 3'b111; din = {P2, P1, P0};
    for (int c = 0; c < 7; c++) begin
      polarity = c[0];
      @(negedge clk);
      checks++;
      if (gnt !== exp_gnt[c]) begin
        errors++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt[c]);
      end
      checks++;
      if (so !== (c != 0)) begin
        errors++; $display("FAIL rr_so c=%0d got=%b want=%b", c, so, (c != 0));
      end
      if (c != 0) begin
        checks++;
        if (dout !== exp_dout[c]) begin
          errors++; $display("FAIL rr_dout c=%0d got=%h want=%h", c, dout, exp_dout[c]);
        end
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ro = 1'b0; din = {P2, P1, P0};
    polarity = 1'b0; req = 3'b001;
    tick();
    polarity = 1'b1; req = 3'b010;
    tick();
    req = 3'b100;
    for (int c = 0; c < 4; c++) begin
      polarity = c[0];
      @(negedge clk);
      checks++;
      if (gnt !== 3'b000 || so !== 1'b0) begin
        errors++; $display("FAIL bp_hold c=%0d got gnt=%b so=%b want 000/0", c, gnt, so);
      end
      tick();
    end
    ro = 1'b1; polarity = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || so !== 1'b1 || dout !== P1) begin
      errors++; $display("FAIL bp_rel0 got gnt=%b so=%b dout=%h want 000/1/%h", gnt, so, dout, P1);
    end
    tick();
    polarity = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b100 || so !== 1'b1 || dout !== P0) begin
      errors++; $display("FAIL bp_rel1 got gnt=%b so=%b dout=%h want 100/1/%h", gnt, so, dout, P0);
    end
    tick();
    polarity = 1'b0; req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || so !== 1'b1 || dout !== P2) begin
      errors++; $display("FAIL bp_rel2 got gnt=%b so=%b dout=%h want 000/1/%h", gnt, so, dout, P2);
    end
    tick();
  endtask

  task automatic test_hop();
    logic [63:0] exp;
`ifdef ROUTER_OUT_HOPSHIFT_EN
    exp = 64'h1240_0000_0000_00FF;
`else
    exp = 64'h1280_0000_0000_00FF;
`endif
    do_reset();
    polarity = 1'b0; req = 3'b001; din = '0; din[63:0] = 64'h1280_0000_0000_00FF;
    tick();
    polarity = 1'b1; req = '0;
    @(negedge clk);
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL hop_so got=%b want=1", so); end
    checks++;
    if (dout !== exp) begin errors++; $display("FAIL hop_dout got=%h want=%h", dout, exp); end
    checks++;
    if (dout[55:48] !== exp[55:48]) begin
      errors++; $display("FAIL hop_field got=%h want=%h", dout[55:48], exp[55:48]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ro = 1'b0; din = {P2, P1, P0};
    polarity = 1'b0; req = 3'b010;
    tick();
    polarity = 1'b1;
    tick();
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0; ro = 1'b1;
    for (int c = 0; c < 2; c++) begin
      polarity = c[0];
      @(negedge clk);
      checks++;
      if (so !== 1'b0 || dout !== 64'h0) begin
        errors++; $display("FAIL rmid_clear c=%0d got so=%b dout=%h want 0/0", c, so, dout);
      end
      tick();
    end
    req = 3'b111;
    for (int c = 0; c < 2; c++) begin
      polarity = c[0];
      @(negedge clk);
      checks++;
      if (gnt !== 3'b001) begin
        errors++; $display("FAIL rmid_ptr c=%0d got=%b want=001", c, gnt);
      end
      tick();
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_backpressure();
    test_hop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_output_ctrl.md
# router_output_ctrl

Output-port controller for the ring router, the transmit counterpart of the router input controller. It arbitrates among internal requesters (input ports and the local PE) for the even/odd virtual-channel output buffers. It drives the external send/ready link to the next router's input controller. Channel roles swap each cycle with `polarity`, mirroring the input controller, so that a packet advances one hop per two cycles.

## Interface
- `NUM_REQ`, default 3 — number of internal requesters (cw input, ccw input, PE).
- `PKT_W`, default 64 — packet width; taken from the shared package.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `polarity`  in  1  global VC phase; 0: internal writes even buffer, external sends odd; 1: internal writes odd buffer, external sends even.
- `req`  in  NUM_REQ  per-requester request, level, held until granted.
- `din`  in  NUM_REQ*PKT_W  requester packets; requester i on bits [i*PKT_W +: PKT_W].
- `gnt`  out  NUM_REQ  one-hot grant, combinational; the requester clears its buffer on this edge.
- `so`  out  1  send-out: packet valid on `dout` and accepted this cycle.
- `ro`  in  1  ready-out from the downstream input controller (its `ri`).
- `dout`  out  PKT_W  outgoing packet.

## Operation
- State: `even_buf`, `odd_buf` (PKT_W), `even_full`, `odd_full`, and one round-robin pointer per VC (`ptr_even`, `ptr_odd`, width clog2(NUM_REQ)).
- Write buffer: even when polarity=0, odd when polarity=1. Send buffer is the other one.
- Arbitration:
  - If the write buffer is empty and any `req` is high, grant the first requester at or after that VC's pointer, scanning upward and wrapping.
  - At most one grant per cycle. No grant while the write buffer is full.
- On a clock edge with a grant: the write buffer takes `din[g]` and its full flag is set. That VC's pointer becomes (g+1) mod NUM_REQ. The other VC's pointer is unchanged.
- Send: `so` = send-buffer full AND `ro`. `dout` = send-buffer contents, always driven, even when `so`=0.
- On a clock edge with `so`: the send buffer's full flag clears. Contents are retained and not zeroed.
- Write and send never target the same buffer in one cycle, so fill and drain in the same cycle are always legal.
- Full write buffer: `gnt`=0 and all requesters hold.
- `ro`=0: the send buffer holds indefinitely, and that VC's writes stall on alternate cycles.
- Reset: both buffers zero, both full flags 0, both pointers 0. Consequently `gnt`=0, `so`=0, `dout`=0.
- Reset mid-operation drops any buffered packets; the caller guarantees requesters are also reset.

## Timing
- Grant: same cycle as `req`, when the write buffer is empty.
- Grant to `so`:
  - Packet written at edge k is in the send buffer during cycle k+1 (polarity flipped).
  - `so` asserts in cycle k+1 if `ro`=1. Minimum latency is 1 cycle.
- Throughput: one packet per VC per 2 cycles, i.e. one packet per cycle aggregate.
- `so` and `gnt` are combinational from registered state plus `polarity`/`ro`/`req`. There is no combinational path from `din` to any output.
- Behaviour is defined cycle-by-cycle from the `polarity` value. A non-toggling `polarity` is legal and simply starves one direction.

## Configuration
- `ROUTER_OUT_HOPSHIFT_EN`:
  - Defined: when a packet is written into a buffer, its hop field (package `HOP_MSB:HOP_LSB`, bits [55:48]) is logically shifted right by one. All other bits pass unchanged.
  - Undefined: the packet is stored and sent bit-exact.

## Structure
- Shared `router_pkg`:
  - `PKT_W`, `VC_BIT` (63), `DIR_BIT` (62), `HOP_MSB`/`HOP_LSB` (55/48).
  - Packet typedef `pkt_t`.
- Sub-module `router_rr_arb`:
  - Parameterized `NUM_REQ`.
  - Inputs: `req`, `ptr`, `en`. Outputs: one-hot `gnt`, encoded `gnt_idx`.
  - Combinational.
  - One instance; the parent muxes the pointer and `en` by polarity and owns both pointer registers.

## Test plan
- Reset, then polarity toggling with `ro`=1 and no `req` -> `so`=0, `gnt`=0, `dout`=0 throughout.
- polarity=0, `req`=3'b001, `din[0]`=64'hA5 -> `gnt`=001 same cycle. Next cycle (polarity=1), `so`=1 and `dout`=64'hA5. Cycle after, `so`=0.
- `req`=3'b111 held, polarity toggling, `ro`=1 -> even-VC grants in order 0,1,2,0 and odd-VC grants 0,1,2 independently. No requester is granted twice before the others.
- `ro`=0 with both buffers filled -> `gnt`=0 and `so`=0 while held. After `ro`=1, each VC sends once on its send cycle and grants resume the following cycle.
- `ROUTER_OUT_HOPSHIFT_EN` defined, `din` hop field 8'h80 -> `dout`[55:48]=8'h40, other bits unchanged. Macro undefined -> 8'h80.
- Reset asserted while both buffers are full -> the next cycle `so`=0, `dout`=0, pointers 0, and the first subsequent grant goes to requester 0.
